cursor_colocacion: RTL and testbench
====================================

CURSOR_COLOCACION -- requirements
Module: cursor_colocacion

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, is the number of consecutive stable cycles required to accept a button level.
REQ-002 Parameter BOARD_N, default 5, is the board edge length; rows and columns are 0..BOARD_N-1.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the asynchronous, active-low reset.
REQ-005 Port btn_up, btn_down, btn_left, btn_right  input  1 each  are raw, asynchronous, active-low cursor buttons.
REQ-006 Port btn_confirm  input  1  is the raw, asynchronous, active-low placement button.
REQ-007 Port colocation_ships_State  input  1  is high while the game is in the ship-placement phase.
REQ-008 Port player_ship_amount_define  input  3  is the number of ships to place; values above 5 are treated as 5.
REQ-009 Port i_actual  output  3  is the cursor row.
REQ-010 Port j_actual  output  3  is the cursor column of the ship's leftmost cell.
REQ-011 Port player_ships_input_internal  output  3  is the current ship length, equal to ship_idx+1.
REQ-012 Port confirm_colocation_button  output  1  is a one-cycle-high placement strobe.
REQ-013 Port placing_done  output  1  is high while all ships are confirmed.

Function
REQ-014 Each button SHALL pass through a 2-FF synchronizer and then a debouncer.
REQ-015 The debounce counter SHALL clear on any change of the synchronized level and SHALL accept the new level after DEBOUNCE_CYCLES consecutive equal samples.
REQ-016 A move event SHALL be an accepted 1->0 (press) transition; a confirm event SHALL be an accepted 0->1 (release) transition of btn_confirm.
REQ-017 The FSM SHALL have three states: IDLE, PLACE, DONE.
REQ-018 IDLE SHALL go to PLACE when colocation_ships_State=1 and the amount is >0, and SHALL go to DONE when colocation_ships_State=1 and the amount is 0.
REQ-019 Entering PLACE SHALL set ship_idx=0, i=0, j=0.
REQ-020 PLACE and DONE SHALL go to IDLE within 1 cycle of colocation_ships_State=0, clearing the cursor, ship_idx, and placing_done.
REQ-021 Up/down SHALL change i by -1/+1 within 0..BOARD_N-1.
REQ-022 Left/right SHALL change j by -1/+1 within 0..BOARD_N-ship_len, so the ship never leaves the board.
REQ-023 At range limits, moves SHALL saturate (see REQ-032 for the wrap option).
REQ-024 Only one action SHALL be applied per cycle, with priority confirm > up > down > left > right; lower-priority events in the same cycle SHALL be dropped.
REQ-025 On a confirm event in PLACE, confirm_colocation_button SHALL be high for exactly the next cycle, with i_actual, j_actual, and player_ships_input_internal held at the confirmed values during that cycle.
REQ-026 In the cycle after the strobe, ship_idx SHALL increment and the cursor SHALL return to (0,0); if the incremented ship_idx equals the amount, the FSM SHALL go to DONE instead.
REQ-027 Move and confirm events in IDLE or DONE SHALL be ignored; no strobe SHALL be produced.
REQ-028 placing_done SHALL be 1 only in DONE; outputs SHALL be registered.

Reset
REQ-029 While rst=0, outputs SHALL be: i_actual=0, j_actual=0, player_ships_input_internal=1, confirm_colocation_button=0, placing_done=0, with the FSM in IDLE.
REQ-030 On reset, debounced levels SHALL be 1 (released) and debounce counters SHALL be 0.
REQ-031 Reset asserted mid-PLACE or during the strobe cycle SHALL abort immediately, and no strobe SHALL follow deassertion.

Configuration
REQ-032 With macro CURSOR_WRAP_EN defined, moves past a limit SHALL wrap (i: 4->0 and 0->4; j: max->0 and 0->max).
REQ-033 Without CURSOR_WRAP_EN, moves past a limit SHALL saturate.

Verification (DEBOUNCE_CYCLES=4)
REQ-034 Amount=3, phase high, press+release btn_right twice -> j_actual=2, i_actual=0; a 2-cycle glitch on btn_right -> no change.
REQ-035 Ship length 3, press right 5 times -> j_actual stops at 2; with CURSOR_WRAP_EN, the 3rd press gives j_actual=0.
REQ-036 Amount=2, place two ships -> two 1-cycle strobes carrying lengths 1 then 2, then placing_done=1; a further confirm gives no strobe.
REQ-037 btn_up and btn_down accepted in the same cycle at i=2 -> i_actual=1; confirm and right in the same cycle -> strobe with the unmoved j.
REQ-038 rst=0 asserted in the strobe cycle -> confirm_colocation_button=0 immediately, all outputs at reset values, FSM in IDLE.
REQ-039 Amount=0 with phase high -> placing_done=1 within 2 cycles and no strobe.

Source files
------------

// File: rtl/cursor_colocacion.sv
// Ship-placement cursor: synchronises and debounces five active-low buttons,
// moves a ship-sized cursor on a BOARD_N x BOARD_N board and emits a one-cycle
// placement strobe per confirmed ship.
// Optional build macro: CURSOR_WRAP_EN (cursor wraps at board limits instead of saturating).
module cursor_colocacion #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BOARD_N         = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_confirm,
  input  logic       colocation_ships_State,
  input  logic [2:0] player_ship_amount_define,
  output logic [2:0] i_actual,
  output logic [2:0] j_actual,
  output logic [2:0] player_ships_input_internal,
  output logic       confirm_colocation_button,
  output logic       placing_done
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, PLACE, DONE} state_t;

  // Bit order: {confirm, right, left, down, up}
  logic [4:0] raw;
  logic [4:0] sync_a, sync_b, sync_c;
  logic [4:0] level, level_q;

  assign raw = {btn_confirm, btn_right, btn_left, btn_down, btn_up};

  // Two-flop synchroniser, a change-detect stage and the previous debounced level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a  <= '1;
      sync_b  <= '1;
      sync_c  <= '1;
      level_q <= '1;
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      sync_c  <= sync_b;
      level_q <= level;
    end
  end

  for (genvar b = 0; b < 5; b++) begin : g_deb
    logic [CW-1:0] cnt;
    logic          lvl;

    // Debouncer: any change of the synchronised level restarts the count;
    // a differing level is accepted after DEBOUNCE_CYCLES equal samples
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
        lvl <= 1'b1;
      end else if (sync_b[b] != sync_c[b]) begin
        cnt <= '0;
      end else if (sync_b[b] == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        lvl <= sync_b[b];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign level[b] = lvl;
  end

  logic ev_up, ev_down, ev_left, ev_right, ev_confirm;

  // Moves act on press (1->0), placement acts on release (0->1)
  assign ev_up      = level_q[0] & ~level[0];
  assign ev_down    = level_q[1] & ~level[1];
  assign ev_left    = level_q[2] & ~level[2];
  assign ev_right   = level_q[3] & ~level[3];
  assign ev_confirm = ~level_q[4] & level[4];

  state_t     state, state_n;
  logic [2:0] i_q, j_q, idx_q;
  logic [2:0] i_n, j_n, idx_n;
  logic       strobe_q, strobe_n;
  logic       done_q, done_n;
  logic [2:0] amount, ship_len, i_max, j_max;

  assign amount   = (player_ship_amount_define > 3'd5) ? 3'd5 : player_ship_amount_define;
  assign ship_len = idx_q + 3'd1;
  assign i_max    = 3'(BOARD_N - 1);
  assign j_max    = 3'(BOARD_N) - ship_len;

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      idx_q    <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      i_q      <= i_n;
      j_q      <= j_n;
      idx_q    <= idx_n;
      strobe_q <= strobe_n;
      done_q   <= done_n;
    end
  end

  // Next-state logic; the cycle after the strobe decides between PLACE and DONE
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (colocation_ships_State)
          state_n = (amount == 3'd0) ? DONE : PLACE;
      end
      PLACE: begin
        if (!colocation_ships_State)
          state_n = IDLE;
        else if (strobe_q && (ship_len == amount))
          state_n = DONE;
      end
      DONE: begin
        if (!colocation_ships_State)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output/datapath logic: one action per cycle, confirm > up > down > left > right.
  // The strobe cycle itself takes no action so the confirmed values stay on the outputs.
  always_comb begin
    i_n      = i_q;
    j_n      = j_q;
    idx_n    = idx_q;
    strobe_n = 1'b0;
    done_n   = (state_n == DONE);
    unique case (state)
      PLACE: begin
        if (!colocation_ships_State) begin
          i_n   = '0;
          j_n   = '0;
          idx_n = '0;
        end else if (strobe_q) begin
          idx_n = idx_q + 3'd1;
          i_n   = '0;
          j_n   = '0;
        end else if (ev_confirm) begin
          strobe_n = 1'b1;
        end else if (ev_up) begin
`ifdef CURSOR_WRAP_EN
          i_n = (i_q == 3'd0) ? i_max : i_q - 3'd1;
`else
          i_n = (i_q == 3'd0) ? 3'd0 : i_q - 3'd1;
`endif
        end else if (ev_down) begin
`ifdef CURSOR_WRAP_EN
          i_n = (i_q >= i_max) ? 3'd0 : i_q + 3'd1;
`else
          i_n = (i_q >= i_max) ? i_max : i_q + 3'd1;
`endif
        end else if (ev_left) begin
`ifdef CURSOR_WRAP_EN
          j_n = (j_q == 3'd0) ? j_max : j_q - 3'd1;
`else
          j_n = (j_q == 3'd0) ? 3'd0 : j_q - 3'd1;
`endif
        end else if (ev_right) begin
`ifdef CURSOR_WRAP_EN
          j_n = (j_q >= j_max) ? 3'd0 : j_q + 3'd1;
`else
          j_n = (j_q >= j_max) ? j_max : j_q + 3'd1;
`endif
        end
      end
      DONE: begin
        if (!colocation_ships_State) begin
          i_n   = '0;
          j_n   = '0;
          idx_n = '0;
        end
      end
      default: begin
        i_n   = '0;
        j_n   = '0;
        idx_n = '0;
      end
    endcase
  end

  assign i_actual                    = i_q;
  assign j_actual                    = j_q;
  assign player_ships_input_internal = ship_len;
  assign confirm_colocation_button   = strobe_q;
  assign placing_done                = done_q;

endmodule

// File: tb/tb_cursor_colocacion.sv
// Randomised scoreboard bench for cursor_colocacion (DEBOUNCE_CYCLES=4, BOARD_N=5).
module tb_cursor_colocacion;
  localparam int DEB  = 4;
  localparam int N    = 5;
  localparam int HOLD = 14;
`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] btn = '1;  // {confirm, right, left, down, up}
  logic       phase = 1'b0;
  logic [2:0] amount = '0;
  logic [2:0] i_actual, j_actual, ship_len;
  logic       strobe, placing_done;

  cursor_colocacion #(.DEBOUNCE_CYCLES(DEB), .BOARD_N(N)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .btn_up                     (btn[0]),
    .btn_down                   (btn[1]),
    .btn_left                   (btn[2]),
    .btn_right                  (btn[3]),
    .btn_confirm                (btn[4]),
    .colocation_ships_State     (phase),
    .player_ship_amount_define  (amount),
    .i_actual                   (i_actual),
    .j_actual                   (j_actual),
    .player_ships_input_internal(ship_len),
    .confirm_colocation_button  (strobe),
    .placing_done               (placing_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {int i; int j; int len;} exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Reference model: cursor position, current ship length, target count
  int m_i, m_j, m_len, m_amt;
  bit m_active, m_done;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_clear();
    m_i = 0; m_j = 0; m_len = 1; m_active = 0; m_done = 0;
  endfunction

  function automatic void m_phase_on();
    m_amt = (amount > 5) ? 5 : int'(amount);
    m_i = 0; m_j = 0; m_len = 1;
    if (m_amt == 0) m_done = 1;
    else m_active = 1;
  endfunction

  // dir: 0 up, 1 down, 2 left, 3 right
  function automatic void m_move(input int dir);
    int lim_i, lim_j;
    lim_i = N - 1;
    lim_j = N - m_len;
    if (!m_active) return;
    case (dir)
      0: m_i = (m_i == 0)      ? (WRAP ? lim_i : 0)     : m_i - 1;
      1: m_i = (m_i >= lim_i)  ? (WRAP ? 0 : lim_i)     : m_i + 1;
      2: m_j = (m_j == 0)      ? (WRAP ? lim_j : 0)     : m_j - 1;
      default: m_j = (m_j >= lim_j) ? (WRAP ? 0 : lim_j) : m_j + 1;
    endcase
  endfunction

  function automatic void m_confirm();
    if (!m_active) return;
    sb.push_back('{m_i, m_j, m_len});
    m_len++;
    m_i = 0;
    m_j = 0;
    if (m_len - 1 == m_amt) begin
      m_active = 0;
      m_done   = 1;
    end
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press several move buttons in the same cycle, then release them
  task automatic press_moves(input logic [3:0] mask);
    if (mask[0]) m_move(0);
    else if (mask[1]) m_move(1);
    else if (mask[2]) m_move(2);
    else if (mask[3]) m_move(3);
    btn[3:0] = btn[3:0] & ~mask;
    wait_cyc(HOLD);
    btn[3:0] = btn[3:0] | mask;
    wait_cyc(HOLD);
  endtask

  task automatic press_confirm();
    m_confirm();
    btn[4] = 1'b0;
    wait_cyc(HOLD);
    btn[4] = 1'b1;
    wait_cyc(HOLD);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".i"}, int'(i_actual), m_i);
    check({tag, ".j"}, int'(j_actual), m_j);
    if (!m_done) check({tag, ".len"}, int'(ship_len), m_len);
    check({tag, ".done"}, int'(placing_done), int'(m_done));
  endtask

  task automatic random_until_done(input int max_actions);
    int r;
    for (int k = 0; k < max_actions && !m_done; k++) begin
      r = $urandom_range(0, 5);
      if (r == 4) press_confirm();
      else if (r == 5) press_moves(4'($urandom_range(1, 15)));
      else press_moves(4'(1 << r));
      check_model("rand");
    end
    for (int k = 0; k < 6 && !m_done; k++) begin
      press_confirm();
      check_model("fill");
    end
  endtask

  // Monitor: every strobe must match the oldest expected placement
  bit prev_strobe = 1'b0;
  always @(negedge clk) begin
    if (strobe) begin
      check("strobe_width", int'(prev_strobe), 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual=1 expected=0 at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        check("strobe.i", int'(i_actual), mon_e.i);
        check("strobe.j", int'(j_actual), mon_e.j);
        check("strobe.len", int'(ship_len), mon_e.len);
      end
    end
    prev_strobe <= strobe;
  end

  initial begin
    bit found;
    m_clear();

    // Reset values
    wait_cyc(3);
    check("rst.i", int'(i_actual), 0);
    check("rst.j", int'(j_actual), 0);
    check("rst.len", int'(ship_len), 1);
    check("rst.strobe", int'(strobe), 0);
    check("rst.done", int'(placing_done), 0);
    rst = 1'b1;
    wait_cyc(2);

    // Amount 3: two right moves, then a short glitch
    amount = 3'd3; phase = 1'b1; m_phase_on();
    wait_cyc(3);
    check_model("start");
    press_moves(4'b1000);
    press_moves(4'b1000);
    check_model("right2");
    btn[3] = 1'b0;
    wait_cyc(2);
    btn[3] = 1'b1;
    wait_cyc(HOLD);
    check_model("glitch");

    // Place two ships, then push a length-3 ship right five times
    press_confirm();
    press_confirm();
    check_model("len3");
    repeat (5) press_moves(4'b1000);
    check_model("limit_right");

    phase = 1'b0; m_clear();
    wait_cyc(2);
    check_model("idle");

    // Amount 2, randomised until done, then an ignored confirm
    amount = 3'd2; phase = 1'b1; m_phase_on();
    wait_cyc(2);
    random_until_done(30);
    check_model("done2");
    press_confirm();
    check_model("done2_extra");
    phase = 1'b0; m_clear();
    wait_cyc(2);

    // Same-cycle up+down at row 2, and same-cycle confirm+right
    amount = 3'd5; phase = 1'b1; m_phase_on();
    wait_cyc(2);
    press_moves(4'b0010);
    press_moves(4'b0010);
    check_model("row2");
    press_moves(4'b0011);
    check_model("updown");
    press_moves(4'b1000);
    btn[4] = 1'b0;
    wait_cyc(HOLD);
    m_confirm();
    btn[4] = 1'b1;
    btn[3] = 1'b0;
    wait_cyc(HOLD);
    btn[3] = 1'b1;
    wait_cyc(HOLD);
    check_model("conf_right");

    // Reset during the strobe cycle
    press_moves(4'b1000);
    btn[4] = 1'b0;
    wait_cyc(HOLD);
    btn[4] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (strobe) begin
        found = 1'b1;
        break;
      end
    end
    check("strobe_seen", int'(found), 1);
    rst = 1'b0;
    #1;
    check("rst_mid.strobe", int'(strobe), 0);
    check("rst_mid.i", int'(i_actual), 0);
    check("rst_mid.j", int'(j_actual), 0);
    check("rst_mid.len", int'(ship_len), 1);
    check("rst_mid.done", int'(placing_done), 0);
    phase = 1'b0; m_clear();
    wait_cyc(5);
    rst = 1'b1;
    wait_cyc(20);
    check_model("after_rst");

    // Amount 0 goes straight to done
    amount = 3'd0; phase = 1'b1; m_phase_on();
    wait_cyc(2);
    check("amt0.done", int'(placing_done), 1);
    press_confirm();
    check_model("amt0");
    phase = 1'b0; m_clear();
    wait_cyc(2);

    // Amount 7 is treated as 5
    amount = 3'd7; phase = 1'b1; m_phase_on();
    wait_cyc(2);
    random_until_done(60);
    check_model("amt7");
    wait_cyc(4);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
